pdm_audio_out: RTL and testbench

- Stereo audio output stage. Consumes the 48 kHz sample strobe and the 4.8 MHz modulator strobe from the decade divider, both derived from the 48 MHz system clock.
- Buffers incoming 16-bit stereo frames in a small FIFO and releases one frame per 48 kHz strobe.
- Each channel drives a first-order delta-sigma modulator at 100x oversampling, producing 1-bit PDM outputs for external RC filters.

---
 rtl/pdm_audio_out_if.sv | 8 +
 rtl/pdm_audio_out.sv | 74 +++++++
 tb/tb_pdm_audio_out.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pdm_audio_out_if.sv
// pdm_audio_out_if: stereo frame valid/ready stream into the PDM output stage
interface pdm_audio_out_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/pdm_audio_out.sv
// pdm_audio_out: stereo frame FIFO released at 48 kHz feeding two first-order delta-sigma PDM modulators
module pdm_audio_out #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pulse_48k,
    input  logic                   pulse_4M8,
    pdm_audio_out_if.slave         s,
    output logic                   pdm_left,
    output logic                   pdm_right,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   underrun,
    output logic [15:0]            underrun_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [LW-1:0] r_level;
    logic [15:0]   r_cur_l, r_cur_r, r_acc_l, r_acc_r, r_ucnt;
    logic          r_pdm_l, r_pdm_r, r_und;
    logic          w_push, w_pop, w_empty;
    logic [16:0]   w_sum_l, w_sum_r;
    always_comb begin
        w_empty = r_level == '0;
        w_push  = s.s_valid && s.s_ready;
        w_pop   = pulse_48k && !w_empty;
        // flipping the sign bit turns signed PCM into offset binary for the accumulator
        w_sum_l = {1'b0, r_acc_l} + {1'b0, ~r_cur_l[15], r_cur_l[14:0]};
        w_sum_r = {1'b0, r_acc_r} + {1'b0, ~r_cur_r[15], r_cur_r[14:0]};
    end
    assign s.s_ready      = !rst && (r_level != LW'(DEPTH));
    assign pdm_left       = r_pdm_l;
    assign pdm_right      = r_pdm_r;
    assign fifo_level     = r_level;
    assign underrun       = r_und;
    assign underrun_count = r_ucnt;
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= s.s_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_cur_l <= '0;
            r_cur_r <= '0;
            r_acc_l <= '0;
            r_acc_r <= '0;
            r_pdm_l <= 1'b0;
            r_pdm_r <= 1'b0;
            r_und   <= 1'b0;
            r_ucnt  <= '0;
        end else begin
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
            r_und   <= pulse_48k && w_empty;
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            // an empty strobe plays silence rather than repeating the last sample
            if (pulse_48k) begin
                r_cur_l <= w_pop ? r_mem[r_rp][31:16] : '0;
                r_cur_r <= w_pop ? r_mem[r_rp][15:0] : '0;
            end
            if (pulse_48k && w_empty && r_ucnt != 16'hFFFF) r_ucnt <= r_ucnt + 16'd1;
            if (pulse_4M8) begin
                r_acc_l <= w_sum_l[15:0];
                r_acc_r <= w_sum_r[15:0];
                r_pdm_l <= w_sum_l[16];
                r_pdm_r <= w_sum_r[16];
            end
        end
    end
endmodule

// File: tb/tb_pdm_audio_out.sv
// tb_pdm_audio_out: scoreboard bench for the FIFO, underrun counter and PDM modulators
module tb_pdm_audio_out;
    localparam int DEPTH = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pulse_48k = 1'b0;
    logic        pulse_4M8 = 1'b0;
    logic        pdm_left, pdm_right, underrun;
    logic [2:0]  fifo_level;
    logic [15:0] underrun_count;
    int          n_tests = 0;
    int          n_fail = 0;
    int          tcnt = 0;
    logic [31:0] m_q[$];
    logic [15:0] m_cur_l = '0, m_cur_r = '0, m_acc_l = '0, m_acc_r = '0, m_ucnt = '0;
    logic        m_pdm_l = 1'b0, m_pdm_r = 1'b0, m_und = 1'b0;
    int          ones;
    logic        b0, b1;
    pdm_audio_out_if bus();
    pdm_audio_out #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pulse_48k(pulse_48k), .pulse_4M8(pulse_4M8), .s(bus),
        .pdm_left(pdm_left), .pdm_right(pdm_right), .fifo_level(fifo_level),
        .underrun(underrun), .underrun_count(underrun_count)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic cyc(input bit p48, input bit v, input logic [31:0] d);
        bit          p4, rdy;
        logic [16:0] sl, sr;
        logic [31:0] f;
        p4 = (tcnt % 10 == 0);
        pulse_48k = p48;
        pulse_4M8 = p4;
        bus.s_valid = v;
        bus.s_data = d;
        #1;
        rdy = !rst && (m_q.size() != DEPTH);
        check("s_ready", bus.s_ready, rdy);
        if (rst) begin
            m_q.delete();
            {m_cur_l, m_cur_r, m_acc_l, m_acc_r, m_ucnt} = '0;
            {m_pdm_l, m_pdm_r, m_und} = '0;
        end else begin
            if (p4) begin
                sl = {1'b0, m_acc_l} + {1'b0, ~m_cur_l[15], m_cur_l[14:0]};
                sr = {1'b0, m_acc_r} + {1'b0, ~m_cur_r[15], m_cur_r[14:0]};
                {m_pdm_l, m_acc_l} = sl;
                {m_pdm_r, m_acc_r} = sr;
            end
            m_und = 1'b0;
            if (p48) begin
                if (m_q.size() > 0) begin
                    f = m_q.pop_front();
                    m_cur_l = f[31:16];
                    m_cur_r = f[15:0];
                end else begin
                    m_cur_l = '0;
                    m_cur_r = '0;
                    m_und = 1'b1;
                    if (m_ucnt != 16'hFFFF) m_ucnt++;
                end
            end
            if (v && rdy) m_q.push_back(d);
        end
        @(posedge clk);
        #1;
        tcnt++;
        bus.s_valid = 1'b0;
        pulse_48k = 1'b0;
        pulse_4M8 = 1'b0;
        check("fifo_level", fifo_level, m_q.size());
        check("underrun", underrun, m_und);
        check("underrun_count", underrun_count, m_ucnt);
        check("pdm_left", pdm_left, m_pdm_l);
        check("pdm_right", pdm_right, m_pdm_r);
    endtask
    task automatic align();
        while (tcnt % 10 != 0) cyc(0, 0, '0);
    endtask
    task automatic period(input logic [31:0] nxt, input bit load, output int n1, output logic f0, output logic f1);
        n1 = 0;
        f0 = 1'b0;
        f1 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            cyc(i == 0, load && i == 500, nxt);
            if (i % 10 == 0) n1 += int'(pdm_left);
            if (i == 0) f0 = pdm_left;
            if (i == 10) f1 = pdm_left;
        end
    endtask
    initial begin
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        repeat (3) cyc(0, 0, '0);
        check("rst_level", fifo_level, 0);
        check("rst_count", underrun_count, 0);
        check("rst_pdm", {pdm_left, pdm_right, underrun}, 0);
        rst = 1'b0;
        cyc(0, 1, 32'h0000_0000);
        align();
        period(32'h8000_8000, 1, ones, b0, b1);
        check("mid_first", b0, 0);
        check("mid_second", b1, 1);
        check("mid_ones", ones, 50);
        period(32'h7FFF_7FFF, 1, ones, b0, b1);
        check("min_ones", ones, 0);
        period('0, 0, ones, b0, b1);
        check("coinc_old", b0, 0);
        check("coinc_new", b1, 1);
        check("max_ones", ones, 99);
        cyc(1, 0, '0);
        check("und_pulse", underrun, 1);
        check("und_count", underrun_count, 1);
        cyc(0, 0, '0);
        check("und_clear", underrun, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 32'hA000_B000 + 32'(i * 32'h0001_0001));
        check("full_level", fifo_level, DEPTH);
        check("full_ready", bus.s_ready, 0);
        cyc(0, 1, 32'hDEAD_BEEF);
        check("full_hold", fifo_level, DEPTH);
        align();
        cyc(1, 0, '0);
        check("pop_level", fifo_level, DEPTH - 1);
        check("pop_ready", bus.s_ready, 1);
        repeat (3) begin
            align();
            cyc(1, 0, '0);
            repeat (60) cyc(0, 0, '0);
        end
        cyc(0, 1, 32'h1111_2222);
        cyc(0, 1, 32'h3333_4444);
        cyc(0, 1, 32'h5555_6666);
        repeat (3) begin
            align();
            cyc(1, 0, '0);
            repeat (99) cyc(0, 0, '0);
        end
        repeat (10) begin
            repeat (3) cyc(0, 1, $urandom);
            repeat (3) begin
                align();
                cyc(1, 0, '0);
                repeat (30) cyc(0, 0, '0);
            end
        end
        repeat (3) cyc(0, 1, $urandom);
        repeat (50) cyc(0, 0, '0);
        check("pre_rst_level", fifo_level, 3);
        rst = 1'b1;
        cyc(0, 0, '0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_pdm", {pdm_left, pdm_right}, 0);
        check("mid_rst_ready", bus.s_ready, 0);
        rst = 1'b0;
        align();
        cyc(1, 0, '0);
        check("post_rst_und", underrun, 1);
        repeat (65540) cyc(1, 0, '0);
        check("und_saturate", underrun_count, 16'hFFFF);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
